// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: sync word then data word, MSB first, then an idle gap.
// First sync bit is registered on the handshake edge; tx_ready is low for the whole frame and gap.
module seq_tx_1011 #(
  parameter int                DATA_W  = 8,
  parameter int                SYNC_W  = 4,
  parameter logic [SYNC_W-1:0] SYNC    = 4'b1011,
  parameter int                GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = SYNC_W + DATA_W;
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_ALL = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic                 dout_q, dout_d;
  logic                 dout_en_q, dout_en_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   frame_load;

  assign frame_load = {SYNC, tx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      dout_q    <= 1'b0;
      dout_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      done_q    <= done_d;
    end
  end

  // state_q names the phase of the bit currently on dout; cnt_q is how many
  // more cycles that phase lasts after the current one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    dout_d    = 1'b0;
    dout_en_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_SYNC;
          cnt_d     = SYNC_LAST;
          dout_d    = frame_load[FRAME_W-1];
          dout_en_d = 1'b1;
          sh_d      = frame_load << 1;
        end
      end
      ST_SYNC: begin
        dout_d    = sh_q[FRAME_W-1];
        dout_en_d = 1'b1;
        sh_d      = sh_q << 1;
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          dout_d    = sh_q[FRAME_W-1];
          dout_en_d = 1'b1;
          sh_d      = sh_q << 1;
          cnt_d     = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    dout     = dout_q;
    dout_en  = dout_en_q;
    done     = done_q;
  end

endmodule
